// File: rtl/shift_pkg.sv
// Shared types for the serial right shifter.
package shift_pkg;

    // Controller states: waiting for operands, stepping the shift, holding the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right_stage.sv
// One log-step of a right shifter: shift by 2^k when enabled, with zero or sign fill.
module shift_right_stage #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  data,
    input  logic [SW-1:0] k,
    input  logic          en,
    input  logic          arith,
    output logic [N-1:0]  shifted
);

    // Shift distance 2^k; the largest value (N/2) fits in SW bits.
    logic [SW-1:0] w_dist;
    logic [N-1:0]  w_srl;
    logic [N-1:0]  w_sra;

    assign w_dist = SW'(1) << k;
    assign w_srl  = data >> w_dist;
    assign w_sra  = $unsigned($signed(data) >>> w_dist);

    // Select the fill flavour, or pass the data through when this step is disabled.
    always_comb begin
        // NOTE: assign a default first in every combinational block so no path leaves the output unassigned and infers a latch.
        shifted = data;
        if (en) begin
            shifted = arith ? w_sra : w_srl;
        end
    end

endmodule

// File: rtl/shift_right_serial.sv
// Multi-cycle logical/arithmetic right shifter: one log-step stage reused over SW cycles,
// with a valid/ready handshake on the operand and result sides.
module shift_right_serial
    import shift_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         arith,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Z,
    output logic         busy
);

    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] K_LAST = SW'(SW - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [N-1:0]  r_work;
    logic [N-1:0]  r_z;
    logic [SW-1:0] r_amt;
    logic [SW-1:0] r_k;
    logic          r_arith;

    logic [N-1:0]  w_stage_out;
    logic          w_accept;
    logic          w_last_step;

    // Only the low SW bits of the amount matter (amount mod N); the rest are deliberately dropped.
    logic          w_unused_b_upper;
    assign w_unused_b_upper = ^B[N-1:SW];

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_last_step = (r_state == SHIFT) && (r_k == K_LAST);

    // The single reused stage; bit k of the captured amount decides whether this step shifts.
    shift_right_stage #(
        .N  (N),
        .SW (SW)
    ) u_stage (
        .data    (r_work),
        .k       (r_k),
        .en      (r_amt[r_k]),
        .arith   (r_arith),
        .shifted (w_stage_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a fixed SW-step walk through SHIFT, then hold in DONE until consumed.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_next_state = SHIFT;
            SHIFT:   if (w_last_step) w_next_state = DONE;
            DONE:    if (out_ready)   w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, step the working value, publish Z on the last step.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_work  <= '0;
            r_amt   <= '0;
            r_arith <= 1'b0;
            r_k     <= '0;
            r_z     <= '0;
        end else if (w_accept) begin
            r_work  <= A;
            r_amt   <= B[SW-1:0];
            r_arith <= arith;
            r_k     <= '0;
        end else if (r_state == SHIFT) begin
            r_work <= w_stage_out;
            r_k    <= r_k + 1'b1;
            if (w_last_step) begin
                r_z <= w_stage_out;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == SHIFT) || (r_state == DONE);
    assign Z         = r_z;

endmodule

// File: tb/tb_shift_right_serial.sv
// Self-checking bench for shift_right_serial (N=32): directed cases plus randomized
// operations against a bit-level reference model.
module tb_shift_right_serial;

    localparam int N = 32;
    localparam int LAT = 5;

    logic         clk;
    logic         rstb;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         arith;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Z;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;

    shift_right_serial #(.N(N)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result bit i takes source bit i+amt, or the fill when that runs off the top.
    function automatic logic [N-1:0] ref_shift(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic ar);
        logic [N-1:0] r;
        int amt;
        amt = int'(b % N);
        for (int i = 0; i < N; i++) begin
            if (i + amt < N) r[i] = a[i + amt];
            else             r[i] = ar ? a[N-1] : 1'b0;
        end
        return r;
    endfunction

    // Issue one operation and wait (bounded) for the result; lat=-1 on timeout.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ar,
                          output logic [N-1:0] z, output int lat, output logic busy_ok);
        @(negedge clk);
        A = a; B = b; arith = ar; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; arith = 1'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 20) begin
            busy_ok = busy_ok & busy & ~in_ready;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        busy_ok = busy_ok & busy;
        z = Z;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; arith = 1'b0;
        #12;
        n_total++;
        if ({in_ready, out_valid, busy} !== 3'b100 || Z !== '0)
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b Z=%h, required 1 0 0 00000000",
                     in_ready, out_valid, busy, Z);
        else n_pass++;
        @(negedge clk); rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic ar, input logic [N-1:0] exp);
        logic [N-1:0] z; int lat; logic bok;
        run_op(a, b, ar, z, lat, bok);
        n_total++;
        if (z !== exp) $display("FAIL %s Z: got %h, required %h", name, z, exp);
        else n_pass++;
        n_total++;
        if (lat !== LAT) $display("FAIL %s latency: got %0d, required %0d", name, lat, LAT);
        else n_pass++;
        n_total++;
        if (bok !== 1'b1) $display("FAIL %s busy/in_ready during op: got %b, required 1", name, bok);
        else n_pass++;
        consume();
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Z !== exp)
            $display("FAIL %s after consume: in_ready=%b out_valid=%b Z=%h, required 1 0 %h",
                     name, in_ready, out_valid, Z, exp);
        else n_pass++;
    endtask

    task automatic test_directed();
        check_op("srl_31",   32'h8000_0000, 32'd31,         1'b0, 32'h0000_0001);
        check_op("sra_31",   32'h8000_0000, 32'd31,         1'b1, 32'hFFFF_FFFF);
        check_op("amt_0",    32'h1234_5678, 32'd0,          1'b0, 32'h1234_5678);
        check_op("sra_hi_b", 32'hF000_0000, 32'hFFFF_FFE4,  1'b1, 32'hFF00_0000);
        check_op("srl_hi_b", 32'hF000_0000, 32'hFFFF_FFE4,  1'b0, 32'h0F00_0000);
    endtask

    task automatic test_backpressure();
        logic [N-1:0] z; int lat; logic bok; logic stable;
        run_op(32'hC000_0003, 32'd1, 1'b1, z, lat, bok);
        n_total++;
        if (z !== 32'hE000_0001) $display("FAIL bp result: got %h, required e0000001", z);
        else n_pass++;
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid; A = $urandom; B = $urandom;
            @(posedge clk); #1;
            stable = stable & (Z === z) & (in_ready === 1'b0) & (out_valid === 1'b1);
        end
        n_total++;
        if (stable !== 1'b1) $display("FAIL bp hold: stable=%b, required 1", stable);
        else n_pass++;
        in_valid = 1'b0;
        consume();
        n_total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || Z !== z)
            $display("FAIL bp release: in_ready=%b busy=%b Z=%h, required 1 0 %h", in_ready, busy, Z, z);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL bp no capture: busy=%b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        A = 32'hDEAD_BEEF; B = 32'd7; arith = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rstb = 1'b0;
        #1;
        n_total++;
        if ({in_ready, out_valid, busy} !== 3'b100 || Z !== '0)
            $display("FAIL async reset: in_ready=%b out_valid=%b busy=%b Z=%h, required 1 0 0 00000000",
                     in_ready, out_valid, busy, Z);
        else n_pass++;
        @(negedge clk); rstb = 1'b1;
        check_op("post_reset", 32'h0000_0100, 32'd8, 1'b0, 32'h0000_0001);
    endtask

    // Result consumed and a new op offered in the same cycle: the accept lands one edge later.
    task automatic test_back_to_back();
        logic [N-1:0] z; int lat; logic bok; logic [N-1:0] a2, b2; logic ar2;
        run_op(32'h0F0F_0F0F, 32'd4, 1'b0, z, lat, bok);
        a2 = $urandom; b2 = $urandom; ar2 = 1'($urandom);
        A = a2; B = b2; arith = ar2; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_total++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL b2b idle cycle: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        n_total++;
        if (lat !== LAT || Z !== ref_shift(a2, b2, ar2))
            $display("FAIL b2b second op: lat=%0d Z=%h, required %0d %h", lat, Z, LAT, ref_shift(a2, b2, ar2));
        else n_pass++;
        consume();
    endtask

    task automatic test_random();
        logic [N-1:0] a, b, z, exp; logic ar; int lat; logic bok;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom; ar = 1'($urandom);
            if (i % 4 == 0) a[N-1] = 1'b1;
            exp = ref_shift(a, b, ar);
            run_op(a, b, ar, z, lat, bok);
            n_total++;
            if (z !== exp || lat !== LAT || bok !== 1'b1)
                $display("FAIL random[%0d] a=%h b=%h ar=%b: Z=%h lat=%0d busy_ok=%b, required %h %0d 1",
                         i, a, b, ar, z, lat, bok, exp, LAT);
            else n_pass++;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
